config_int_add_clk_gate: RTL and testbench
==========================================

// Module: config_int_add_clk_gate
// PURPOSE
// - Configurable-precision 32-bit two's-complement integer adder with registered operands and result.
// - Low-order operand bits sit behind a clock-gated register bank; reg_en selects exact or approximate mode.
// - Exact mode: low bank clocked. Approximate mode: low bank gated off to save dynamic power.
// - Datapath leaf for approximate-computing accumulators; one result per cycle, fully pipelined.
// PARAMETERS
// - DATA_PATH_BITWIDTH   32  operand/result width (W)
// - CLKGATED_BITWIDTH    16  number of LSBs of each operand held in the gated bank (G); 0 < G <= W
// PORTS
// - clk     in   1   single clock; all state updates on rising edge
// - rst     in   1   asynchronous, active-low reset
// - reg_en  in   1   1 = low bank clocked (exact add); 0 = low bank clock gated (approximate)
// - a       in   W   operand A, signed two's complement
// - b       in   W   operand B, signed two's complement
// - c       out  W   registered sum, signed two's complement
// BEHAVIOUR
// - Reset (rst=0, async): all operand registers and c clear to 0 immediately; held until rst=1 and next edge.
// - Stage 1: upper bank a_q[W-1:G], b_q[W-1:G] loads a,b on every rising edge (ungated clock).
// - Stage 1: lower bank a_q[G-1:0], b_q[G-1:0] is clocked by a gated clock gclk = clk & en_l.
// - en_l is reg_en captured by a latch transparent while clk=0 (glitch-free ICG); reg_en must be stable around rising edge.
// - reg_en=0: lower bank holds last value (0 after reset); no toggling of those flops.
// - Stage 2: c <= a_q + b_q, full W-bit add, carry from lower into upper half propagates; result wraps mod 2^W.
// - No overflow flag; signed overflow wraps silently (0x7FFFFFFF+1 -> 0x80000000).
// - Latency: 2 rising edges from a/b valid to c valid; throughput 1 per cycle; no handshake.
// - reg_en toggle takes effect on the first rising edge after it changes; in-flight stage-2 data unaffected.
// - Reset mid-operation: pipeline contents discarded; c=0 until two edges after rst deasserts.
// - Clock gate is a separate submodule (latch + AND) so synthesis can map it to an ICG cell.
// CONFIGURATION
// - GATED_ZERO_EN defined: while en_l=0 the lower G bits fed to the adder are forced to 0 (gated bank still holds);
//   approximate result is exact upper sum with lower G bits of c = 0.
// - GATED_ZERO_EN undefined: adder uses held lower-bank values (stale LSBs contribute to sum and carry).
// - Both builds identical when reg_en=1.
// TESTING
// - Reset: rst=0 with a=b=0x12345678 -> c=0 asynchronously, stays 0 while rst=0.
// - Exact: reg_en=1, a=5, b=-3 -> c=2 two edges later; a=0x0000FFFF,b=1 -> c=0x00010000 (carry across G).
// - Approx after reset: reg_en=0, a=0x00010001, b=0x00020002 -> c=0x00030000 (lower bank still 0).
// - Stale LSBs: reg_en=1 load a=0x00000003,b=0x00000004, then reg_en=0 with a=0x00100000,b=0 ->
//   c=0x00100007 without GATED_ZERO_EN, 0x00100000 with it.
// - Wrap: reg_en=1, a=0x7FFFFFFF, b=1 -> c=0x80000000; a=-1, b=-1 -> c=0xFFFFFFFE.
// - Streaming: 5000 random pairs at 1/cycle, reg_en=1 -> each c equals signed a+b of pair from 2 cycles earlier.

Source files
------------

// File: rtl/config_int_add_clk_gate.sv
// Configurable-precision adder: low operand bits sit in a clock-gated bank, reg_en picks exact/approx.
// Optional build macro GATED_ZERO_EN forces gated LSBs to zero at the adder while the bank is gated.

module config_int_add_clk_gate_cg (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  // Transparent while clk is low so en_l is frozen during the high phase: no gclk glitches.
  always_latch begin
    if (!clk) en_l = en;
  end

  assign gclk = clk & en_l;

endmodule

module config_int_add_clk_gate #(
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned CLKGATED_BITWIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          reg_en,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic [DATA_PATH_BITWIDTH-1:0] c
);

  localparam int unsigned W = DATA_PATH_BITWIDTH;
  localparam int unsigned G = CLKGATED_BITWIDTH;

  logic         gclk;
  logic [G-1:0] a_lo_q, b_lo_q;
  logic [G-1:0] a_lo_sum, b_lo_sum;
  logic [W-1:0] a_full, b_full;
  logic [W-1:0] c_q;

  config_int_add_clk_gate_cg u_cg (
    .clk  (clk),
    .en   (reg_en),
    .gclk (gclk)
  );

  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      a_lo_q <= '0;
      b_lo_q <= '0;
    end else begin
      a_lo_q <= a[G-1:0];
      b_lo_q <= b[G-1:0];
    end
  end

`ifdef GATED_ZERO_EN
  // Travels with the operands so a reg_en change never alters data already in stage 1.
  logic lo_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_valid_q <= 1'b0;
    end else begin
      lo_valid_q <= reg_en;
    end
  end

  assign a_lo_sum = lo_valid_q ? a_lo_q : '0;
  assign b_lo_sum = lo_valid_q ? b_lo_q : '0;
`else
  assign a_lo_sum = a_lo_q;
  assign b_lo_sum = b_lo_q;
`endif

  if (G < W) begin : gen_hi
    logic [W-G-1:0] a_hi_q, b_hi_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        a_hi_q <= '0;
        b_hi_q <= '0;
      end else begin
        a_hi_q <= a[W-1:G];
        b_hi_q <= b[W-1:G];
      end
    end

    assign a_full = {a_hi_q, a_lo_sum};
    assign b_full = {b_hi_q, b_lo_sum};
  end else begin : gen_no_hi
    assign a_full = a_lo_sum;
    assign b_full = b_lo_sum;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
    end else begin
      c_q <= a_full + b_full;
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_config_int_add_clk_gate.sv
// Directed and streaming checks for config_int_add_clk_gate (default 32/16 configuration).

module tb_config_int_add_clk_gate;

  logic        clk;
  logic        rst;
  logic        reg_en;
  logic [31:0] a, b, c;

  int checks = 0;
  int errors = 0;

  config_int_add_clk_gate #(
    .DATA_PATH_BITWIDTH (32),
    .CLKGATED_BITWIDTH  (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .reg_en (reg_en),
    .a      (a),
    .b      (b),
    .c      (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive inputs mid-cycle, away from the rising edge.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic en);
    @(negedge clk);
    a      = av;
    b      = bv;
    reg_en = en;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] ra, rb;
  logic [31:0] exp_v;

  initial begin
    rst    = 1'b0;
    reg_en = 1'b1;
    a      = 32'h1234_5678;
    b      = 32'h1234_5678;
    #1;
    check("reset_initial", c, 32'h0);
    settle(2);
    check("reset_held", c, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    settle(1);
    check("post_reset_edge1", c, 32'h0);
    settle(1);
    check("post_reset_edge2", c, 32'h2468_ACF0);

    // Async reset: c must clear without waiting for an edge.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", c, 32'h0);
    settle(2);
    check("async_reset_held", c, 32'h0);

    // Approximate mode straight after reset: lower bank still zero.
    drive(32'h0001_0001, 32'h0002_0002, 1'b0);
    rst = 1'b1;
    settle(2);
    check("approx_after_reset", c, 32'h0003_0000);

    drive(32'd5, 32'hFFFF_FFFD, 1'b1);
    settle(2);
    check("exact_5_m3", c, 32'd2);

    drive(32'h0000_FFFF, 32'd1, 1'b1);
    settle(2);
    check("exact_carry_g", c, 32'h0001_0000);

    drive(32'h7FFF_FFFF, 32'd1, 1'b1);
    settle(2);
    check("wrap_pos", c, 32'h8000_0000);

    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    settle(2);
    check("wrap_neg", c, 32'hFFFF_FFFE);

    // Stale LSBs: load 3/4 exactly, then gate the bank.
    drive(32'd3, 32'd4, 1'b1);
    drive(32'h0010_0000, 32'd0, 1'b0);
    settle(1);
    check("inflight_exact", c, 32'd7);
    settle(1);
`ifdef GATED_ZERO_EN
    check("stale_lsb", c, 32'h0010_0000);
`else
    check("stale_lsb", c, 32'h0010_0007);
`endif

    drive(32'h0005_0007, 32'h0001_0001, 1'b0);
    settle(2);
`ifdef GATED_ZERO_EN
    check("approx_upper_only", c, 32'h0006_0000);
`else
    check("approx_upper_only", c, 32'h0006_0007);
`endif

    drive(32'h0000_0010, 32'h0000_0020, 1'b1);
    settle(2);
    check("exact_reenabled", c, 32'h0000_0030);

    // Streaming: one random pair per cycle, result two edges later.
    for (int i = 0; i < 5002; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp_v = exp_q.pop_front();
        check("stream", c, exp_v);
      end
      if (i < 5000) begin
        ra = $urandom;
        rb = $urandom;
      end else begin
        ra = 32'h0;
        rb = 32'h0;
      end
      a      = ra;
      b      = rb;
      reg_en = 1'b1;
      exp_q.push_back(ra + rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
